// File: rtl/dual_source_bus_arbiter.sv
// Round-robin arbiter for two 32-bit requesters sharing one mux slot, with a bounded
// burst length and a one-entry valid/ready output register.
module dual_source_bus_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready,
    output logic             select,
    output logic [CNT_W-1:0] burst_count
);

    // Handshake: a word moves on a rising edge exactly when valid & ready are both
    // high for that side; ready never looks at the same side's valid, and once
    // y_valid is high y_data/y_valid hold until y_ready is seen.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_B = CNT_W'(MAX_BURST);

    state_t           state, state_next;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] count_inc;
    logic             last_served_b, last_next;
    logic             slot_free;
    logic             a_xfer, b_xfer, xfer;
    logic             grant_b;
    logic             own_valid, other_valid;
    state_t           other_state;
    logic [WIDTH-1:0] mux_data;

    assign slot_free = ~y_valid | y_ready;
    assign a_ready   = (state == GRANT_A) & slot_free;
    assign b_ready   = (state == GRANT_B) & slot_free;
    assign a_xfer    = a_valid & a_ready;
    assign b_xfer    = b_valid & b_ready;
    assign xfer      = a_xfer | b_xfer;
    assign select    = (state == GRANT_B);
    assign mux_data  = select ? b_data : a_data;

    assign grant_b     = (state == GRANT_B);
    assign own_valid   = grant_b ? b_valid : a_valid;
    assign other_valid = grant_b ? a_valid : b_valid;
    assign other_state = grant_b ? GRANT_A : GRANT_B;
    assign count_inc   = burst_count + 1'b1;

    always_comb begin
        state_next = state;
        count_next = burst_count;
        last_next  = last_served_b;
        case (state)
            IDLE: begin
                count_next = '0;
                // On a tie the side that was not served last wins.
                if (a_valid && (!b_valid || last_served_b)) begin
                    state_next = GRANT_A;
                end else if (b_valid) begin
                    state_next = GRANT_B;
                end
            end
            GRANT_A, GRANT_B: begin
                if (xfer) begin
                    if (count_inc == MAX_B) begin
                        count_next = '0;
                        if (other_valid) begin
                            state_next = other_state;
                            last_next  = grant_b;
                        end
                    end else begin
                        count_next = count_inc;
                    end
                end else if (!own_valid) begin
                    count_next = '0;
                    last_next  = grant_b;
                    state_next = other_valid ? other_state : IDLE;
                end
                // own_valid but no slot: backpressure, hold everything.
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            burst_count   <= '0;
            last_served_b <= 1'b1;
        end else begin
            state         <= state_next;
            burst_count   <= count_next;
            last_served_b <= last_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_valid <= 1'b0;
            y_data  <= '0;
        end else if (xfer) begin
            y_valid <= 1'b1;
            y_data  <= mux_data;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dual_source_bus_arbiter.sv
// Directed bench for dual_source_bus_arbiter: reset, first grant, round-robin bursts,
// backpressure, bubble on source drop, single-source wrap and async reset.
module tb_dual_source_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic [31:0] a_data = '0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [31:0] b_data = '0;
    logic        b_ready;
    logic        y_valid;
    logic [31:0] y_data;
    logic        y_ready = 1'b0;
    logic        select;
    logic [3:0]  burst_count;

    int checks = 0;
    int failures = 0;

    dual_source_bus_arbiter #(.WIDTH(32), .MAX_BURST(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
        .select(select), .burst_count(burst_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_valid = 1'b0;
        b_valid = 1'b0;
        y_ready = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    logic [31:0] exp_y   [0:11] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB0, 32'hB1,
                                    32'hB2, 32'hB3, 32'hA4, 32'hA5, 32'hA6, 32'hA7};
    logic [31:0] exp_sel [0:11] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    logic [31:0] exp_cnt [0:11] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};

    initial begin
        int a_idx;
        int b_idx;
        logic ta, tb;

        // Reset values
        tick();
        check_eq("rst_y_valid", 32'(y_valid), 0);
        check_eq("rst_y_data", y_data, 0);
        check_eq("rst_count", 32'(burst_count), 0);
        check_eq("rst_select", 32'(select), 0);
        check_eq("rst_a_ready", 32'(a_ready), 0);
        check_eq("rst_b_ready", 32'(b_ready), 0);
        #2 rst = 1'b0;

        // First grant to A: one IDLE cycle, then transfer
        a_valid = 1'b1; a_data = 32'h11111111; y_ready = 1'b1;
        #1;
        check_eq("t1_c1_select", 32'(select), 0);
        check_eq("t1_c1_a_ready", 32'(a_ready), 0);
        tick();
        check_eq("t1_c2_a_ready", 32'(a_ready), 1);
        check_eq("t1_c2_select", 32'(select), 0);
        tick();
        check_eq("t1_y_valid", 32'(y_valid), 1);
        check_eq("t1_y_data", y_data, 32'h11111111);
        check_eq("t1_count", 32'(burst_count), 1);

        // Round-robin bursts with both sources always valid
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
        a_idx = 0; b_idx = 0;
        a_data = 32'hA0; b_data = 32'hB0;
        tick();
        for (int i = 0; i < 12; i++) begin
            a_data = 32'hA0 + 32'(a_idx);
            b_data = 32'hB0 + 32'(b_idx);
            #1;
            ta = a_ready; tb = b_ready;
            check_eq($sformatf("rr_one_ready_%0d", i), 32'(ta) + 32'(tb), 1);
            tick();
            if (ta) a_idx++;
            if (tb) b_idx++;
            check_eq($sformatf("rr_y_data_%0d", i), y_data, exp_y[i]);
            check_eq($sformatf("rr_select_%0d", i), 32'(select), exp_sel[i]);
            check_eq($sformatf("rr_count_%0d", i), 32'(burst_count), exp_cnt[i]);
        end

        // Backpressure holds output, ready and count
        do_reset();
        a_valid = 1'b1; a_data = 32'hDEADBEEF; y_ready = 1'b1;
        tick();
        tick();
        check_eq("bp_load", y_data, 32'hDEADBEEF);
        a_data = 32'h12345678; y_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq($sformatf("bp_a_ready_%0d", i), 32'(a_ready), 0);
            tick();
            check_eq($sformatf("bp_y_data_%0d", i), y_data, 32'hDEADBEEF);
            check_eq($sformatf("bp_y_valid_%0d", i), 32'(y_valid), 1);
            check_eq($sformatf("bp_count_%0d", i), 32'(burst_count), 1);
        end
        y_ready = 1'b1;
        #1;
        check_eq("bp_release_a_ready", 32'(a_ready), 1);
        tick();
        check_eq("bp_next_word", y_data, 32'h12345678);
        check_eq("bp_next_valid", 32'(y_valid), 1);
        check_eq("bp_next_count", 32'(burst_count), 2);

        // A drops after two transfers while B waits: one bubble, then B
        do_reset();
        a_valid = 1'b1; a_data = 32'h0A0A0A0A; y_ready = 1'b1;
        tick();
        tick();
        tick();
        check_eq("sw_count_before", 32'(burst_count), 2);
        a_valid = 1'b0; b_valid = 1'b1; b_data = 32'hB00000B0;
        #1;
        check_eq("sw_bubble_b_ready", 32'(b_ready), 0);
        tick();
        check_eq("sw_select", 32'(select), 1);
        check_eq("sw_count_restart", 32'(burst_count), 0);
        check_eq("sw_bubble_y_valid", 32'(y_valid), 0);
        check_eq("sw_b_ready", 32'(b_ready), 1);
        tick();
        check_eq("sw_b_data", y_data, 32'hB00000B0);
        check_eq("sw_b_count", 32'(burst_count), 1);

        // Only B requesting: continuous ready, count wraps, never IDLE
        do_reset();
        b_valid = 1'b1; y_ready = 1'b1;
        tick();
        for (int k = 1; k <= 10; k++) begin
            b_data = 32'hB0 + 32'(k);
            #1;
            check_eq($sformatf("bo_b_ready_%0d", k), 32'(b_ready), 1);
            check_eq($sformatf("bo_select_%0d", k), 32'(select), 1);
            tick();
            check_eq($sformatf("bo_count_%0d", k), 32'(burst_count), 32'(k % 4));
            check_eq($sformatf("bo_y_data_%0d", k), y_data, 32'hB0 + 32'(k));
        end

        // Asynchronous reset mid-burst
        #3;
        rst = 1'b1;
        #1;
        check_eq("ar_y_valid", 32'(y_valid), 0);
        check_eq("ar_select", 32'(select), 0);
        check_eq("ar_count", 32'(burst_count), 0);
        check_eq("ar_a_ready", 32'(a_ready), 0);
        check_eq("ar_b_ready", 32'(b_ready), 0);
        check_eq("ar_y_data", y_data, 0);
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        #1;
        check_eq("ar_first_select", 32'(select), 0);
        check_eq("ar_first_a_ready", 32'(a_ready), 1);
        check_eq("ar_first_b_ready", 32'(b_ready), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dual_source_bus_arbiter.md
Name: dual_source_bus_arbiter

Overview:
- Shares one 32-bit datapath slot between two requesters, A and B. Typical uses are a register-file write port or a memory address bus.
- Drives the select line of the shared 32-bit 2:1 mux. The mux output is captured into a one-entry output register with a valid/ready handshake.
- Arbitration is round-robin with a bounded burst length, so neither requester can starve the other.
- Sits between the execution-stage producers and the shared resource.

Parameters:
- WIDTH, 32, data width of each source and of the output.
- MAX_BURST, 4, maximum consecutive transfers granted to one source while the other is waiting. Legal range 1..15.
- CNT_W, 4, width of the burst counter. Must satisfy 2^CNT_W > MAX_BURST.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  source A has data.
- a_data  in  WIDTH  source A data.
- a_ready  out  1  source A transfer accepted this cycle.
- b_valid  in  1  source B has data.
- b_data  in  WIDTH  source B data.
- b_ready  out  1  source B transfer accepted this cycle.
- y_valid  out  1  output register holds data.
- y_data  out  WIDTH  output register contents.
- y_ready  in  1  downstream consumes y_data this cycle.
- select  out  1  mux select: 0 = A, 1 = B; high exactly when the FSM is in GRANT_B.
- burst_count  out  CNT_W  transfers in the current grant.

Behaviour:
- Reset (async, immediate), regardless of activity:
  - FSM = IDLE, y_valid = 0, y_data = 0, burst_count = 0, select = 0.
  - last_served = B, so A wins the first tie.
  - Data held in the output register is discarded.
- FSM states: IDLE, GRANT_A, GRANT_B.
- Slot free: slot_free = ~y_valid | y_ready.
- Ready outputs:
  - a_ready = (state==GRANT_A) & slot_free.
  - b_ready = (state==GRANT_B) & slot_free.
  - Ready never depends combinationally on the same source's valid.
  - Both ready outputs are 0 in IDLE.
- Transfer: X_valid & X_ready on an edge. That edge loads y_data <= X_data (through the mux) and sets y_valid = 1. Output latency is 1 cycle.
- y_valid clears on an edge with y_ready & ~transfer.
- While y_valid & ~y_ready, y_data and y_valid are held stable.
- IDLE:
  - Both valid: grant the source that is NOT last_served.
  - Only one valid: grant it.
  - Neither valid: stay in IDLE.
  - The new grant takes effect next cycle; burst_count = 0.
- GRANT_X, transfer edge:
  - burst_count increments.
  - If the new count == MAX_BURST and the other source is valid: switch to GRANT_other, count = 0, last_served = X. There is no bubble; the other source may transfer on the very next cycle.
  - If the new count == MAX_BURST and the other source is idle: keep GRANT_X, count = 0.
- GRANT_X, no transfer while X_valid = 0:
  - Other source valid: switch to GRANT_other, count = 0, last_served = X. This costs a one-cycle bubble.
  - Otherwise: go to IDLE, count = 0, last_served = X.
- GRANT_X, no transfer while X_valid & ~slot_free (backpressure): hold the state and count; no switch.
- Simultaneous output drain and new transfer on one edge: y_valid stays 1 and y_data takes the new value.
- Zero-bubble streaming within a grant: one transfer per cycle while y_ready = 1.
- burst_count never exceeds MAX_BURST-1 when observed after an edge.

Test Plan:
- Reset, then a_valid = 1 with a_data = 0x11111111, b_valid = 0, y_ready = 1:
  - Cycle 1: select = 0.
  - Cycle 2: a_ready = 1.
  - After that edge: y_valid = 1, y_data = 0x11111111.
- a_valid and b_valid held at 1, y_ready = 1, MAX_BURST = 4, A sends 0xA0..0xA7, B sends 0xB0..0xB7:
  - y_data sequence is A0,A1,A2,A3,B0,B1,B2,B3,A4,…
  - No bubble at switch points; select toggles each time burst_count wraps.
- Backpressure: y_ready = 0 for 5 cycles with y_valid = 1 holding 0xDEADBEEF:
  - y_data stays stable, a_ready = 0, burst_count is frozen.
  - When y_ready rises, 0xDEADBEEF drains and the next word loads on the same edge.
- In GRANT_A after 2 transfers, a_valid drops while b_valid = 1:
  - One idle cycle with no ready asserted, then select = 1 and b_ready = 1.
  - burst_count restarts from 0.
- Only B requesting for 10 cycles: select stays 1, b_ready is asserted continuously, burst_count wraps 0,1,2,3,0,…, and B is never forced into IDLE.
- Assert rst mid-burst with y_valid = 1, asynchronously between edges:
  - y_valid, select, burst_count and both ready outputs go to 0 immediately.
  - After release with both sources valid, A is granted first.
